// File: rtl/clk_phase_pkg.sv
// Shared types and reset defaults for the clk_phase_gen phase/strobe generator.
package clk_phase_pkg;

  localparam int CFG_FW     = 16;
  localparam int MAX_CH     = 16;
  localparam int DEF_PER_M1 = 20;

  typedef struct packed {
    logic [CFG_FW-1:0] start;
    logic [CFG_FW-1:0] stop;
    logic              inv;
  } ch_cfg_t;

  localparam int DEF_START [MAX_CH] = '{0, 0, 0, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int DEF_STOP  [MAX_CH] = '{11, 11, 20, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam bit DEF_INV   [MAX_CH] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic ch_cfg_t def_cfg(input logic [3:0] ch);
    ch_cfg_t c;
    c.start = CFG_FW'(DEF_START[ch]);
    c.stop  = CFG_FW'(DEF_STOP[ch]);
    c.inv   = DEF_INV[ch];
    return c;
  endfunction

endpackage

// File: rtl/clk_phase_cmp.sv
// Window compare for one channel: [start, stop) with wrap-around when start > stop.
module clk_phase_cmp #(
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0] c,
  input  logic [CNT_W-1:0] start,
  input  logic [CNT_W-1:0] stop,
  input  logic             inv,
  output logic             ph
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    if (start < stop)
      hit = (c >= start) && (c < stop);
    else if (start > stop)
      hit = (c >= start) || (c < stop);
    ph = hit ^ inv;
  end

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel phase enable generator: one modulo counter, double-buffered
// period and per-channel window configs that switch only at the period boundary.
module clk_phase_gen
  import clk_phase_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              per_we,
  input  logic [CNT_W-1:0]  per_m1,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_start,
  input  logic [CNT_W-1:0]  cfg_stop,
  input  logic              cfg_inv,
  output logic [CNT_W-1:0]  count,
  output logic [NUM_CH-1:0] ph_out,
  output logic              wrap,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  act_per;
  logic [CNT_W-1:0]  sh_per;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] hit;
  logic              ld;

  // ">=" rather than "==" so an out-of-range count falls back to 0
  assign ld      = en && (count >= act_per);
  assign wrap    = en && (count == act_per);
  assign cnt_nxt = (count >= act_per) ? '0 : count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      ph_out  <= '0;
      cfg_err <= 1'b0;
      sh_per  <= CNT_W'(DEF_PER_M1);
      act_per <= CNT_W'(DEF_PER_M1);
    end else begin
      cfg_err <= cfg_we && (int'(cfg_ch) >= NUM_CH);
      if (per_we)
        sh_per <= per_m1;
      if (ld)
        act_per <= sh_per;
      if (en) begin
        count  <= cnt_nxt;
        ph_out <= hit;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam ch_cfg_t DEF = def_cfg(4'(i));

    logic [CNT_W-1:0] sh_start, sh_stop, act_start, act_stop;
    logic             sh_inv, act_inv, sel;

    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_start  <= CNT_W'(DEF.start);
        sh_stop   <= CNT_W'(DEF.stop);
        sh_inv    <= DEF.inv;
        act_start <= CNT_W'(DEF.start);
        act_stop  <= CNT_W'(DEF.stop);
        act_inv   <= DEF.inv;
      end else begin
        if (sel) begin
          sh_start <= cfg_start;
          sh_stop  <= cfg_stop;
          sh_inv   <= cfg_inv;
        end
        if (ld) begin
          act_start <= sh_start;
          act_stop  <= sh_stop;
          act_inv   <= sh_inv;
        end
      end
    end

    // Count 0 of a new period must already see the config being loaded
    clk_phase_cmp #(.CNT_W(CNT_W)) u_cmp (
      .c     (cnt_nxt),
      .start (ld ? sh_start : act_start),
      .stop  (ld ? sh_stop  : act_stop),
      .inv   (ld ? sh_inv   : act_inv),
      .ph    (hit[i])
    );
  end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: default-period table plus corner-case sequences.
module tb_clk_phase_gen;

  logic       clk = 1'b0;
  logic       rst_n, en, per_we, cfg_we, cfg_inv;
  logic [5:0] per_m1, cfg_start, cfg_stop;
  logic [1:0] cfg_ch;
  logic [5:0] count, count3;
  logic [3:0] ph_out;
  logic [2:0] ph3;
  logic       wrap, cfg_err, wrap3, err3;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  clk_phase_gen #(.CNT_W(6), .NUM_CH(4), .CH_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .per_we(per_we), .per_m1(per_m1),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_inv(cfg_inv), .count(count), .ph_out(ph_out), .wrap(wrap), .cfg_err(cfg_err)
  );

  clk_phase_gen #(.CNT_W(6), .NUM_CH(3), .CH_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .per_we(per_we), .per_m1(per_m1),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_inv(cfg_inv), .count(count3), .ph_out(ph3), .wrap(wrap3), .cfg_err(err3)
  );

  typedef struct {
    int         cnt;
    logic [3:0] ph;
    logic       wrap;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int tgt);
    int n = 0;
    while (count !== 6'(tgt) && n < 64) begin
      step();
      n++;
    end
    if (count !== 6'(tgt)) begin
      tot_cnt++;
      $display("FAIL run_to: count %0d never reached %0d", count, tgt);
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input int s, input int e, input logic inv);
    cfg_we = 1'b1; cfg_ch = ch; cfg_start = 6'(s); cfg_stop = 6'(e); cfg_inv = inv;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [3:0] frz_ph;

    // Default period of 21: ph bits are {ch3, ch2, ch1, ch0}
    vec[0] = '{0, 4'b0000, 1'b0};
    for (int c = 1;  c <= 10; c++) vec[c] = '{c, 4'b0101, 1'b0};
    for (int c = 11; c <= 17; c++) vec[c] = '{c, 4'b0110, 1'b0};
    vec[18] = '{18, 4'b1110, 1'b0};
    vec[19] = '{19, 4'b1110, 1'b0};
    vec[20] = '{20, 4'b0010, 1'b1};
    vec[21] = '{0,  4'b0101, 1'b0};
    vec[22] = '{1,  4'b0101, 1'b0};

    rst_n = 1'b0; en = 1'b0; per_we = 1'b0; per_m1 = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_start = '0; cfg_stop = '0; cfg_inv = 1'b0;
    repeat (3) step();
    chk("rst_count", 32'(count), 0);
    chk("rst_ph", 32'(ph_out), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(cfg_err), 0);

    en = 1'b1;
    rst_n = 1'b1;
    #1;
    for (int r = 0; r < 23; r++) begin
      if (r > 0) step();
      chk($sformatf("t1_cnt[%0d]", r), 32'(count), 32'(vec[r].cnt));
      chk($sformatf("t1_ph[%0d]", r), 32'(ph_out), 32'(vec[r].ph));
      chk($sformatf("t1_wrap[%0d]", r), 32'(wrap), 32'(vec[r].wrap));
    end

    // Period change mid-period takes effect only after the current wrap
    run_to(5);
    per_we = 1'b1; per_m1 = 6'd7;
    step();
    per_we = 1'b0;
    run_to(20);
    chk("t2_wrap20", 32'(wrap), 1);
    step();
    chk("t2_cnt0", 32'(count), 0);
    run_to(7);
    chk("t2_wrap7", 32'(wrap), 1);
    step();
    chk("t2_cnt_after7", 32'(count), 0);

    // Period back to 20 and wrap-around window on ch2, written in the same cycle
    per_we = 1'b1; per_m1 = 6'd20;
    write_cfg(2'd2, 15, 3, 1'b0);
    per_we = 1'b0;
    run_to(7);
    step();
    chk("t3_ch2_c0", 32'(ph_out[2]), 1);
    run_to(2);
    chk("t3_ch2_c2", 32'(ph_out[2]), 1);
    step();
    chk("t3_ch2_c3", 32'(ph_out[2]), 0);
    run_to(14);
    chk("t3_ch2_c14", 32'(ph_out[2]), 0);
    step();
    chk("t3_ch2_c15", 32'(ph_out[2]), 1);
    run_to(20);
    chk("t3_ch2_c20", 32'(ph_out[2]), 1);
    chk("t3_wrap20", 32'(wrap), 1);

    // Write in the wrap cycle lands one period later
    write_cfg(2'd1, 9, 9, 1'b1);
    chk("t4_ch1_old_c0", 32'(ph_out[1]), 0);
    run_to(11);
    chk("t4_ch1_old_c11", 32'(ph_out[1]), 1);
    run_to(20);
    step();
    chk("t4_ch1_inv_c0", 32'(ph_out[1]), 1);
    run_to(15);
    chk("t4_ch1_inv_c15", 32'(ph_out[1]), 1);
    write_cfg(2'd1, 9, 9, 1'b0);
    run_to(20);
    step();
    chk("t4_ch1_noinv_c0", 32'(ph_out[1]), 0);
    run_to(10);
    chk("t4_ch1_noinv_c10", 32'(ph_out[1]), 0);

    // Freeze
    run_to(12);
    frz_ph = ph_out;
    chk("t5_ph_c12", 32'(ph_out), 32'(4'b0000));
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t5_frz_cnt[%0d]", k), 32'(count), 12);
      chk($sformatf("t5_frz_ph[%0d]", k), 32'(ph_out), 32'(frz_ph));
      chk($sformatf("t5_frz_wrap[%0d]", k), 32'(wrap), 0);
    end
    en = 1'b1;
    step();
    chk("t5_resume", 32'(count), 13);
    run_to(20);
    chk("t5_wrap_en1", 32'(wrap), 1);
    en = 1'b0;
    #1;
    chk("t5_wrap_en0", 32'(wrap), 0);
    step();
    chk("t5_hold20", 32'(count), 20);
    en = 1'b1;
    step();
    chk("t5_cnt0", 32'(count), 0);

    // Out-of-range channel on the 3-channel build
    write_cfg(2'd3, 5, 6, 1'b0);
    chk("t6_err3", 32'(err3), 1);
    chk("t6_err4", 32'(cfg_err), 0);
    step();
    chk("t6_err3_pulse", 32'(err3), 0);
    run_to(20);
    step();
    run_to(5);
    chk("t6_ph4_c5", 32'(ph_out), 32'(4'b1001));
    chk("t6_ph3_c5", 32'(ph3), 32'(3'b001));
    chk("t6_cnt3", 32'(count3), 5);
    step();
    chk("t6_ch3_c6", 32'(ph_out[3]), 0);

    // Async reset mid-period discards a pending period write
    per_we = 1'b1; per_m1 = 6'd3;
    step();
    per_we = 1'b0;
    run_to(9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", 32'(count), 0);
    chk("t6_rst_ph", 32'(ph_out), 0);
    chk("t6_rst_wrap", 32'(wrap), 0);
    chk("t6_rst_cnt3", 32'(count3), 0);
    repeat (2) step();
    rst_n = 1'b1;
    run_to(5);
    chk("t6_def_c5", 32'(ph_out), 32'(4'b0101));
    run_to(18);
    chk("t6_def_c18", 32'(ph_out), 32'(4'b1110));
    run_to(20);
    chk("t6_def_c20", 32'(ph_out), 32'(4'b0010));
    chk("t6_def_wrap", 32'(wrap), 1);
    step();
    chk("t6_def_cnt0", 32'(count), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
